// File: rtl/rf_port_sequencer_if.sv
// Bundles the decode request, ALU operand/result handshakes and the
// register-file port that rf_port_sequencer drives.
// master: the environment (decode, ALU, register file).
// slave: the sequencer.
interface rf_port_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [SELW-1:0]  src_a;
  logic [SELW-1:0]  src_b;
  logic [SELW-1:0]  dst;
  logic             dst_en;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             opnd_valid;
  logic             opnd_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready;
  logic [SELW-1:0]  rf_sel;
  logic [1:0]       rf_mode;
  logic [WIDTH-1:0] rf_wdata;
  logic [WIDTH-1:0] rf_rdata;
  logic             busy;

  modport master (
    output req_valid, src_a, src_b, dst, dst_en,
    output opnd_ready, res_valid, res_data, rf_rdata,
    input  req_ready, opa, opb, opnd_valid, res_ready,
    input  rf_sel, rf_mode, rf_wdata, busy
  );

  modport slave (
    input  req_valid, src_a, src_b, dst, dst_en,
    input  opnd_ready, res_valid, res_data, rf_rdata,
    output req_ready, opa, opb, opnd_valid, res_ready,
    output rf_sel, rf_mode, rf_wdata, busy
  );
endinterface

// File: rtl/rf_port_sequencer.sv
// Single-port 64x16 register file sequencer: reads two source operands
// back to back, presents them to the ALU, then writes the ALU result to
// the destination register. Only one request is in flight at a time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | ready for a request, RF idles on reg 0 in read mode
// RD_A     | RF address = src_a (read issued)
// RD_B     | RF address = src_b, capture src_a data into opa
// CAP_B    | hold src_b address, capture src_b data into opb
// PRESENT  | operands valid, wait for ALU handshake
// WAIT_RES | wait for ALU result, capture it into rf_wdata
// WB       | RF address = dst in write mode, write lands on exit edge
module rf_port_sequencer #(
  parameter int         WIDTH   = 16,
  parameter int         SELW    = 6,
  parameter logic [1:0] MODE_RD = 2'b01,
  parameter logic [1:0] MODE_WR = 2'b10
) (
  input logic                clk,
  input logic                clear,
  rf_port_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_A     = 3'd1;
  localparam logic [2:0] S_RD_B     = 3'd2;
  localparam logic [2:0] S_CAP_B    = 3'd3;
  localparam logic [2:0] S_PRESENT  = 3'd4;
  localparam logic [2:0] S_WAIT_RES = 3'd5;
  localparam logic [2:0] S_WB       = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [SELW-1:0]  src_a_q, src_b_q, dst_q;
  logic             dst_en_q;
  logic [WIDTH-1:0] opa_q, opb_q, wdata_q;
  logic             accept;
  logic             res_take;

  // Handshakes are qualified by clear so nothing is accepted in a clear cycle.
  assign accept   = (state_q == S_IDLE) && bus.req_valid && !clear;
  assign res_take = (state_q == S_WAIT_RES) && bus.res_valid;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.req_valid) state_d = S_RD_A;
      S_RD_A:     state_d = S_RD_B;
      S_RD_B:     state_d = S_CAP_B;
      S_CAP_B:    state_d = S_PRESENT;
      S_PRESENT:  if (bus.opnd_ready) state_d = dst_en_q ? S_WAIT_RES : S_IDLE;
      S_WAIT_RES: if (bus.res_valid) state_d = S_WB;
      S_WB:       state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State, request latch, operand capture and write-data capture.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q  <= S_IDLE;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      dst_en_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_a_q  <= bus.src_a;
        src_b_q  <= bus.src_b;
        dst_q    <= bus.dst;
        dst_en_q <= bus.dst_en;
      end
      // Read latency is one cycle: RD_B sees src_a data, CAP_B sees src_b data.
      if (state_q == S_RD_B)  opa_q <= bus.rf_rdata;
      if (state_q == S_CAP_B) opb_q <= bus.rf_rdata;
      if (res_take)           wdata_q <= bus.res_data;
    end
  end

  // Register-file port drive; clear suppresses the write in a WB cycle.
  always_comb begin
    bus.rf_sel  = '0;
    bus.rf_mode = MODE_RD;
    case (state_q)
      S_RD_A:  bus.rf_sel = src_a_q;
      S_RD_B:  bus.rf_sel = src_b_q;
      S_CAP_B: bus.rf_sel = src_b_q;
      S_WB: begin
        if (!clear) begin
          bus.rf_sel  = dst_q;
          bus.rf_mode = MODE_WR;
        end
      end
      default: begin
        bus.rf_sel  = '0;
        bus.rf_mode = MODE_RD;
      end
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) && !clear;
    bus.opnd_valid = (state_q == S_PRESENT) && !clear;
    bus.res_ready  = (state_q == S_WAIT_RES) && !clear;
    bus.busy       = (state_q != S_IDLE);
    bus.opa        = opa_q;
    bus.opb        = opb_q;
    bus.rf_wdata   = wdata_q;
  end

  // A write strobe outside WB would corrupt the register file.
  rf_mode_wr_only_in_wb: assert property (
    @(posedge clk) (bus.rf_mode == MODE_WR) |-> (state_q == S_WB)
  );

endmodule

// File: tb/tb_rf_port_sequencer.sv
// Bench for rf_port_sequencer: behavioural 64x16 register file with
// one-cycle read latency, scoreboard queues for operands and writes.
module tb_rf_port_sequencer;
  localparam logic [1:0] MODE_RD = 2'b01;
  localparam logic [1:0] MODE_WR = 2'b10;

  logic clk = 1'b0;
  logic clear;
  int   n_checks = 0;
  int   n_errors = 0;

  rf_port_sequencer_if #(.WIDTH(16), .SELW(6)) bus();

  rf_port_sequencer #(
    .WIDTH(16), .SELW(6), .MODE_RD(MODE_RD), .MODE_WR(MODE_WR)
  ) dut (
    .clk(clk),
    .clear(clear),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64] = '{default: 16'h0};
  logic [15:0] exp_rf [64] = '{default: 16'h0};
  int          wr_cnt = 0;
  logic [21:0] wr_log [$];
  logic [21:0] wr_q [$];
  logic [31:0] op_q [$];

  // Register file model: one-cycle read latency, write on MODE_WR edge.
  always @(posedge clk) begin
    if (bus.rf_mode == MODE_WR) begin
      mem[bus.rf_sel] <= bus.rf_wdata;
      wr_cnt <= wr_cnt + 1;
      wr_log.push_back({bus.rf_sel, bus.rf_wdata});
    end else begin
      bus.rf_rdata <= mem[bus.rf_sel];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request: accept, read, present (optionally stalled), write back.
  task automatic run_req(input logic [5:0] a, input logic [5:0] b, input logic [5:0] d,
                         input logic en, input logic [15:0] res, input int stall);
    int lat;
    int wc0;
    logic [15:0] hold_a, hold_b;
    logic [31:0] eo;
    logic [21:0] ew, ow;
    bus.req_valid = 1'b1; bus.src_a = a; bus.src_b = b; bus.dst = d; bus.dst_en = en;
    bus.opnd_ready = (stall == 0);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL req_ready_idle: got %b expected 1", bus.req_ready); end
    op_q.push_back({exp_rf[a], exp_rf[b]});
    wc0 = wr_cnt;
    tick();
    bus.req_valid = 1'b0; bus.src_a = ~a; bus.src_b = ~b; bus.dst = ~d; bus.dst_en = ~en;
    lat = 1;
    while (!bus.opnd_valid && lat < 20) begin tick(); lat++; end
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL opnd_latency: got %0d expected 4", lat); end
    if (stall > 0) begin
      hold_a = bus.opa; hold_b = bus.opb;
      for (int i = 0; i < stall; i++) begin
        tick();
        n_checks++;
        if (bus.opnd_valid !== 1'b1 || bus.opa !== hold_a || bus.opb !== hold_b || wr_cnt !== wc0) begin
          n_errors++;
          $display("FAIL stall_hold: valid=%b opa=%h opb=%h writes=%0d expected valid=1 opa=%h opb=%h writes=%0d",
                   bus.opnd_valid, bus.opa, bus.opb, wr_cnt, hold_a, hold_b, wc0);
        end
      end
      bus.opnd_ready = 1'b1;
    end
    eo = op_q.pop_front();
    n_checks++;
    if ({bus.opa, bus.opb} !== eo) begin n_errors++; $display("FAIL operands: got %h/%h expected %h/%h", bus.opa, bus.opb, eo[31:16], eo[15:0]); end
    tick();
    bus.opnd_ready = 1'b0;
    if (en) begin
      n_checks++;
      if (bus.res_ready !== 1'b1) begin n_errors++; $display("FAIL res_ready: got %b expected 1", bus.res_ready); end
      wr_q.push_back({d, res});
      bus.res_valid = 1'b1; bus.res_data = res;
      tick();
      bus.res_valid = 1'b0; bus.res_data = 16'h0;
      n_checks++;
      if (bus.rf_mode !== MODE_WR || bus.rf_sel !== d || bus.rf_wdata !== res) begin
        n_errors++;
        $display("FAIL wb_drive: mode=%b sel=%0d wdata=%h expected mode=%b sel=%0d wdata=%h",
                 bus.rf_mode, bus.rf_sel, bus.rf_wdata, MODE_WR, d, res);
      end
      tick();
      n_checks++;
      if (wr_cnt !== wc0 + 1) begin n_errors++; $display("FAIL write_count: got %0d expected %0d", wr_cnt - wc0, 1); end
      ew = wr_q.pop_front();
      ow = (wr_log.size() > 0) ? wr_log.pop_front() : 22'h3fffff;
      n_checks++;
      if (ow !== ew) begin n_errors++; $display("FAIL write_data: got sel=%0d data=%h expected sel=%0d data=%h", ow[21:16], ow[15:0], ew[21:16], ew[15:0]); end
      exp_rf[d] = res;
    end else begin
      n_checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || wr_cnt !== wc0) begin
        n_errors++;
        $display("FAIL no_wb_return: req_ready=%b busy=%b writes=%0d expected 1 0 0", bus.req_ready, bus.busy, wr_cnt - wc0);
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    tick(); tick();
    n_checks++;
    if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_during: req_ready=%b busy=%b expected 0 0", bus.req_ready, bus.busy); end
    clear = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.opnd_valid !== 1'b0 || bus.res_ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_hs: req_ready=%b opnd_valid=%b res_ready=%b expected 1 0 0", bus.req_ready, bus.opnd_valid, bus.res_ready);
    end
    n_checks++;
    if (bus.rf_sel !== 6'd0 || bus.rf_mode !== MODE_RD || bus.rf_wdata !== 16'h0) begin
      n_errors++; $display("FAIL reset_rf: sel=%0d mode=%b wdata=%h expected 0 %b 0000", bus.rf_sel, bus.rf_mode, bus.rf_wdata, MODE_RD);
    end
    n_checks++;
    if (bus.opa !== 16'h0 || bus.opb !== 16'h0) begin n_errors++; $display("FAIL reset_ops: opa=%h opb=%h expected 0000 0000", bus.opa, bus.opb); end
    tick();
  endtask

  task automatic test_preload();
    run_req(6'd0, 6'd0, 6'd3, 1'b1, 16'h000f, 0);
    run_req(6'd0, 6'd0, 6'd5, 1'b1, 16'h0010, 0);
    run_req(6'd0, 6'd0, 6'd2, 1'b1, 16'habcd, 0);
    run_req(6'd0, 6'd0, 6'd4, 1'b1, 16'h0001, 0);
  endtask

  task automatic test_writeback();
    run_req(6'd3, 6'd5, 6'd7, 1'b1, 16'h001f, 0);
    run_req(6'd7, 6'd7, 6'd0, 1'b0, 16'h0, 0);
  endtask

  task automatic test_backpressure();
    run_req(6'd3, 6'd5, 6'd8, 1'b1, 16'h1234, 5);
    run_req(6'd8, 6'd3, 6'd0, 1'b0, 16'h0, 0);
  endtask

  task automatic test_no_writeback();
    run_req(6'd2, 6'd2, 6'd0, 1'b0, 16'h0, 0);
  endtask

  task automatic test_hazard();
    run_req(6'd4, 6'd5, 6'd4, 1'b1, 16'h0002, 0);
    run_req(6'd4, 6'd4, 6'd0, 1'b0, 16'h0, 0);
  endtask

  task automatic test_clear_mid();
    int lat;
    int wc0;
    wc0 = wr_cnt;
    bus.req_valid = 1'b1; bus.src_a = 6'd1; bus.src_b = 6'd1; bus.dst = 6'd9; bus.dst_en = 1'b1; bus.opnd_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.opnd_valid && lat < 20) begin tick(); lat++; end
    tick();
    bus.opnd_ready = 1'b0;
    n_checks++;
    if (bus.res_ready !== 1'b1) begin n_errors++; $display("FAIL clr_wait_res_entry: res_ready=%b expected 1", bus.res_ready); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.res_ready !== 1'b0 || bus.req_ready !== 1'b1 || wr_cnt !== wc0) begin
      n_errors++; $display("FAIL clr_wait_res: busy=%b res_ready=%b req_ready=%b writes=%0d expected 0 0 1 0", bus.busy, bus.res_ready, bus.req_ready, wr_cnt - wc0);
    end
    bus.req_valid = 1'b1; bus.opnd_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.opnd_valid && lat < 20) begin tick(); lat++; end
    tick();
    bus.opnd_ready = 1'b0;
    bus.res_valid = 1'b1; bus.res_data = 16'hbeef;
    tick();
    bus.res_valid = 1'b0;
    n_checks++;
    if (bus.rf_mode !== MODE_WR) begin n_errors++; $display("FAIL clr_wb_entry: mode=%b expected %b", bus.rf_mode, MODE_WR); end
    clear = 1'b1;
    #1;
    n_checks++;
    if (bus.rf_mode !== MODE_RD) begin n_errors++; $display("FAIL clr_wb_override: mode=%b expected %b", bus.rf_mode, MODE_RD); end
    tick();
    clear = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rf_wdata !== 16'h0 || wr_cnt !== wc0) begin
      n_errors++; $display("FAIL clr_wb: busy=%b wdata=%h writes=%0d expected 0 0000 0", bus.busy, bus.rf_wdata, wr_cnt - wc0);
    end
    run_req(6'd9, 6'd9, 6'd0, 1'b0, 16'h0, 0);
  endtask

  task automatic test_stray();
    int lat;
    int wc0;
    logic [31:0] eo;
    wc0 = wr_cnt;
    bus.res_valid = 1'b1; bus.res_data = 16'hdead;
    tick(); tick(); tick();
    n_checks++;
    if (bus.res_ready !== 1'b0 || bus.busy !== 1'b0 || wr_cnt !== wc0) begin
      n_errors++; $display("FAIL stray_idle: res_ready=%b busy=%b writes=%0d expected 0 0 0", bus.res_ready, bus.busy, wr_cnt - wc0);
    end
    bus.req_valid = 1'b1; bus.src_a = 6'd3; bus.src_b = 6'd5; bus.dst = 6'd3; bus.dst_en = 1'b0; bus.opnd_ready = 1'b0;
    op_q.push_back({exp_rf[3], exp_rf[5]});
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.opnd_valid && lat < 20) begin tick(); lat++; end
    n_checks++;
    if (lat !== 4) begin n_errors++; $display("FAIL stray_latency: got %0d expected 4", lat); end
    tick(); tick();
    n_checks++;
    if (bus.res_ready !== 1'b0 || bus.opnd_valid !== 1'b1) begin
      n_errors++; $display("FAIL stray_present: res_ready=%b opnd_valid=%b expected 0 1", bus.res_ready, bus.opnd_valid);
    end
    bus.opnd_ready = 1'b1;
    eo = op_q.pop_front();
    n_checks++;
    if ({bus.opa, bus.opb} !== eo) begin n_errors++; $display("FAIL stray_operands: got %h/%h expected %h/%h", bus.opa, bus.opb, eo[31:16], eo[15:0]); end
    tick();
    bus.opnd_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = 16'h0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || wr_cnt !== wc0) begin n_errors++; $display("FAIL stray_end: busy=%b writes=%0d expected 0 0", bus.busy, wr_cnt - wc0); end
    run_req(6'd3, 6'd5, 6'd0, 1'b0, 16'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b1;
    bus.req_valid = 1'b0; bus.src_a = '0; bus.src_b = '0; bus.dst = '0; bus.dst_en = 1'b0;
    bus.opnd_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
    #1;
    test_reset();
    test_preload();
    test_writeback();
    test_backpressure();
    test_no_writeback();
    test_hazard();
    test_clear_mid();
    test_stray();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rf_port_sequencer.md
Name: rf_port_sequencer

Overview:
- Sequences the single-port 64x16 register file so one instruction can read two source operands and then write one result.
- Sits between decode and the ALU: accepts one register request, performs two back-to-back reads, hands the operands to the ALU, then writes the ALU result back to the destination.
- Strictly one request in flight at a time, so there are no read-after-write hazards.

Parameters:
- WIDTH, 16, data word width (matches `WORD).
- SELW, 6, register select width (64 registers).
- MODE_RD, `regModeOut, rf_mode value driven for a read.
- MODE_WR, `regModeIn, rf_mode value driven for a write.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clear  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- src_a  in  SELW  first source register.
- src_b  in  SELW  second source register.
- dst  in  SELW  destination register.
- dst_en  in  1  result write-back required.
- opa  out  WIDTH  operand A.
- opb  out  WIDTH  operand B.
- opnd_valid  out  1  operands valid.
- opnd_ready  in  1  ALU accepts operands.
- res_valid  in  1  ALU result present.
- res_data  in  WIDTH  ALU result.
- res_ready  out  1  sequencer accepts result.
- rf_sel  out  SELW  register file reg_sel.
- rf_mode  out  2  register file mode.
- rf_wdata  out  WIDTH  register file data_in.
- rf_rdata  in  WIDTH  register file data_out.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: single clock clk; clear is synchronous, active-high and overrides all other inputs.
- Reset values (cycle after clear is sampled high):
  - state IDLE; req_ready=0 while clear=1, then 1.
  - opa=opb=0; opnd_valid=0; res_ready=0; busy=0.
  - rf_sel=0; rf_mode=MODE_RD; rf_wdata=0.
- Register file timing: read latency is 1. An address driven with MODE_RD in cycle t produces valid rf_rdata in cycle t+1. A write occurs at the edge ending a cycle that drives MODE_WR.
- Request latch: src_a, src_b, dst and dst_en are latched on the req_valid&req_ready edge. Later changes to these inputs are ignored until the sequencer returns to IDLE.
- States:
  - IDLE: req_ready=1, rf_sel=0, rf_mode=MODE_RD. On handshake -> RD_A.
  - RD_A: rf_sel=src_a, MODE_RD -> RD_B.
  - RD_B: rf_sel=src_b, MODE_RD; opa<=rf_rdata at end of cycle -> CAP_B.
  - CAP_B: rf_sel=src_b, MODE_RD; opb<=rf_rdata -> PRESENT.
  - PRESENT: opnd_valid=1. opa and opb are held stable until opnd_ready. On handshake -> WAIT_RES if dst_en, else -> IDLE.
  - WAIT_RES: res_ready=1. On res_valid, rf_wdata<=res_data -> WB.
  - WB: rf_sel=dst, rf_mode=MODE_WR, rf_wdata held -> IDLE.
- Latency: with opnd_ready tied to 1, opnd_valid rises 4 cycles after the accepting edge. The write occurs 1 cycle after the result handshake.
- Maximum throughput: one request per 7 cycles with dst_en=1, or per 5 cycles with dst_en=0.
- res_valid outside WAIT_RES is ignored. This includes a res_valid in the same cycle as the operand handshake; the ALU must hold it.
- src_a==src_b: both reads are still performed, and opa==opb.
- dst equal to a source: no hazard, since the write completes before the next acceptance.
- Register 0 is an ordinary register with no special handling.
- rf_mode is never MODE_WR outside WB. Exactly one write occurs per dst_en request.
- clear mid-operation (any state): return to IDLE next cycle and discard the latched request. No write is issued, including a clear asserted during WB, because clear overrides the WB drive in that cycle. opnd_valid and res_ready drop immediately.
- Outputs opa and opb keep their last captured values after the handshake until the next capture or clear.

Test Plan:
- Write-back path: preload r3=16'h000f and r5=16'h0010 via a write-only request path. Request src_a=3, src_b=5, dst=7, dst_en=1, opnd_ready=1 -> opnd_valid 4 cycles after acceptance with opa=000f, opb=0010. Then res_data=001f -> r7 reads 001f, and rf_mode=MODE_WR for exactly 1 cycle.
- Back-pressure: opnd_ready held 0 for 5 cycles -> opa and opb are stable and opnd_valid stays 1; no rf_mode=MODE_WR occurs. Release -> normal completion.
- No write-back: dst_en=0, src_a=src_b=2 (r2=16'habcd) -> opa=opb=abcd, return to IDLE after the operand handshake, no write, and req_ready=1 five cycles after acceptance.
- Hazard case: src_a=4, dst=4, r4=0001, result 0002 -> the next request reading r4 sees 0002.
- Reset mid-operation: clear asserted in WAIT_RES, then again in WB -> IDLE next cycle, busy=0, and the destination register is unchanged (verified by a read).
- Stray result: res_valid=1 with res_data=dead in IDLE and PRESENT -> ignored, no register changes, res_ready stays 0.
